rr_req_arbiter: RTL and testbench

//  Round-robin arbiter with valid/ready handshakes. It shares one downstream

---
 rtl/rr_req_arbiter.sv | 105 ++++++++++
 tb/tb_rr_req_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// Round-robin valid/ready arbiter: combinational grant from a rotating pointer,
// with a lock that pins the grant while the downstream stalls.
module rr_req_arbiter #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxW      = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumIn-1:0]           req_valid_i,
  input  logic [NumIn*DataWidth-1:0] req_data_i,
  output logic [NumIn-1:0]           req_ready_o,
  output logic                       gnt_valid_o,
  input  logic                       gnt_ready_i,
  output logic [DataWidth-1:0]       gnt_data_o,
  output logic [IdxW-1:0]            gnt_idx_o,
  output logic                       proto_err_o
);

  localparam logic [IdxW:0] NumInW = (IdxW+1)'(NumIn);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            proto_err_q, proto_err_d;

  logic [IdxW-1:0] cand;
  logic            gnt_valid;
  logic [IdxW:0]   scan;
  logic [IdxW:0]   ptr_nxt;

  // Scan runs from the highest offset down so the last hit is the one closest to ptr_q.
  always_comb begin
    cand      = '0;
    gnt_valid = 1'b0;
    scan      = '0;
    if (lock_q) begin
      cand      = lock_idx_q;
      gnt_valid = req_valid_i[lock_idx_q];
    end else begin
      gnt_valid = |req_valid_i;
      for (int i = NumIn - 1; i >= 0; i--) begin
        scan = {1'b0, ptr_q} + (IdxW+1)'(i);
        if (scan >= NumInW) begin
          scan = scan - NumInW;
        end
        if (req_valid_i[scan[IdxW-1:0]]) begin
          cand = scan[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_data_o  = '0;
    req_ready_o = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (gnt_valid && (cand == IdxW'(k))) begin
        gnt_data_o     = req_data_i[k*DataWidth +: DataWidth];
        req_ready_o[k] = gnt_ready_i;
      end
    end
  end

  assign gnt_valid_o = gnt_valid;
  assign gnt_idx_o   = cand;
  assign proto_err_o = proto_err_q;

  // A locked requester that withdraws valid is an error; its lock is released without rotating.
  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    proto_err_d = proto_err_q;
    ptr_nxt     = {1'b0, cand} + (IdxW+1)'(1);
    if (ptr_nxt >= NumInW) begin
      ptr_nxt = '0;
    end
    if (lock_q && !gnt_valid) begin
      proto_err_d = 1'b1;
      lock_d      = 1'b0;
    end else if (gnt_valid && gnt_ready_i) begin
      ptr_d  = ptr_nxt[IdxW-1:0];
      lock_d = 1'b0;
    end else if (gnt_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: a 4-input instance driven from a vector
// table, plus a 3-input instance for wrap and reset-mid-stall sequences.
module tb_rr_req_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       rdy;
    logic       expGv;
    logic [1:0] expIdx;
    logic [3:0] expRr;
    logic       expErr;
    logic       chkIdx;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  reqValid4;
  logic [127:0] reqData4;
  logic [3:0]  reqReady4;
  logic        gntValid4;
  logic        gntReady4;
  logic [31:0] gntData4;
  logic [1:0]  gntIdx4;
  logic        protoErr4;

  logic [2:0]  reqValid3;
  logic [23:0] reqData3;
  logic [2:0]  reqReady3;
  logic        gntValid3;
  logic        gntReady3;
  logic [7:0]  gntData3;
  logic [1:0]  gntIdx3;
  logic        protoErr3;

  int nChecks;
  int nFails;
  vec_t vecs[$];

  rr_req_arbiter #(.NumIn(4), .DataWidth(32)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid4), .req_data_i(reqData4), .req_ready_o(reqReady4),
    .gnt_valid_o(gntValid4), .gnt_ready_i(gntReady4), .gnt_data_o(gntData4),
    .gnt_idx_o(gntIdx4), .proto_err_o(protoErr4)
  );

  rr_req_arbiter #(.NumIn(3), .DataWidth(8)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid3), .req_data_i(reqData3), .req_ready_o(reqReady3),
    .gnt_valid_o(gntValid3), .gnt_ready_i(gntReady3), .gnt_data_o(gntData3),
    .gnt_idx_o(gntIdx3), .proto_err_o(protoErr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data4(input logic [1:0] k);
    return 32'hD0D0_0000 + 32'(k) * 32'h111;
  endfunction

  function automatic vec_t row(input logic r, input logic [3:0] v, input logic rd,
                               input logic gv, input logic [1:0] idx,
                               input logic [3:0] rr, input logic err, input logic ci);
    vec_t x;
    x.rst = r; x.valid = v; x.rdy = rd; x.expGv = gv; x.expIdx = idx;
    x.expRr = rr; x.expErr = err; x.chkIdx = ci;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  // Inputs change just after the falling edge; outputs are sampled well before the next rising edge.
  task automatic applyStimulus(input vec_t v, input int n);
    @(negedge clk);
    reqValid4 = v.valid;
    gntReady4 = v.rdy;
    if (v.rst) pulseReset();
    #2;
    checkOutput($sformatf("v%0d gnt_valid", n), 32'(gntValid4), 32'(v.expGv));
    checkOutput($sformatf("v%0d req_ready", n), 32'(reqReady4), 32'(v.expRr));
    checkOutput($sformatf("v%0d proto_err", n), 32'(protoErr4), 32'(v.expErr));
    if (v.chkIdx) begin
      checkOutput($sformatf("v%0d gnt_idx", n), 32'(gntIdx4), 32'(v.expIdx));
      checkOutput($sformatf("v%0d gnt_data", n), gntData4, v.expGv ? data4(v.expIdx) : 32'h0);
    end
  endtask

  task automatic step3(input logic [2:0] v, input logic rd, input logic gv,
                       input logic [1:0] idx, input logic [2:0] rr, input string tag);
    @(negedge clk);
    reqValid3 = v;
    gntReady3 = rd;
    #2;
    checkOutput({tag, " gnt_valid"}, 32'(gntValid3), 32'(gv));
    checkOutput({tag, " gnt_idx"}, 32'(gntIdx3), 32'(idx));
    checkOutput({tag, " gnt_data"}, 32'(gntData3), gv ? 32'(8'h30 + 8'(idx)) : 32'h0);
    checkOutput({tag, " req_ready"}, 32'(reqReady3), 32'(rr));
  endtask

  initial begin
    nChecks   = 0;
    nFails    = 0;
    rst       = 1'b1;
    reqValid4 = '0;
    gntReady4 = 1'b0;
    reqValid3 = '0;
    gntReady3 = 1'b0;
    for (int k = 0; k < 4; k++) reqData4[k*32 +: 32] = data4(2'(k));
    for (int k = 0; k < 3; k++) reqData3[k*8 +: 8] = 8'h30 + 8'(k);

    // reset state
    vecs.push_back(row(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 1));
    // all valid, always ready: plain rotation
    for (int i = 0; i < 8; i++)
      vecs.push_back(row(0, 4'b1111, 1, 1, 2'(i % 4), 4'(1 << (i % 4)), 0, 1));
    // sparse valids from reset
    vecs.push_back(row(1, 4'b1010, 1, 1, 1, 4'b0010, 0, 1));
    vecs.push_back(row(0, 4'b1010, 1, 1, 3, 4'b1000, 0, 1));
    vecs.push_back(row(0, 4'b1010, 1, 1, 1, 4'b0010, 0, 1));
    vecs.push_back(row(0, 4'b1010, 1, 1, 3, 4'b1000, 0, 1));
    // stall on 0 for three cycles, then handshake, then rotation to 1
    for (int i = 0; i < 3; i++)
      vecs.push_back(row(0, 4'b0011, 0, 1, 0, 4'b0000, 0, 1));
    vecs.push_back(row(0, 4'b0011, 1, 1, 0, 4'b0001, 0, 1));
    vecs.push_back(row(0, 4'b0011, 1, 1, 1, 4'b0010, 0, 1));
    // locked on 2 while 3 arrives
    vecs.push_back(row(0, 4'b0100, 0, 1, 2, 4'b0000, 0, 1));
    vecs.push_back(row(0, 4'b1100, 0, 1, 2, 4'b0000, 0, 1));
    vecs.push_back(row(0, 4'b1100, 1, 1, 2, 4'b0100, 0, 1));
    vecs.push_back(row(0, 4'b1100, 1, 1, 3, 4'b1000, 0, 1));
    // locked requester 1 drops valid
    vecs.push_back(row(1, 4'b0010, 0, 1, 1, 4'b0000, 0, 1));
    vecs.push_back(row(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(row(0, 4'b0001, 1, 1, 0, 4'b0001, 1, 1));
    vecs.push_back(row(0, 4'b1111, 1, 1, 1, 4'b0010, 1, 1));
    vecs.push_back(row(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(row(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));

    #3;
    rst = 1'b0;
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    reqValid4 = '0;
    gntReady4 = 1'b0;
    @(negedge clk);
    pulseReset();
    // three requesters: wrap must go 2 -> 0
    step3(3'b111, 1, 1, 0, 3'b001, "n3 r0");
    step3(3'b111, 1, 1, 1, 3'b010, "n3 r1");
    step3(3'b111, 1, 1, 2, 3'b100, "n3 r2");
    step3(3'b111, 1, 1, 0, 3'b001, "n3 r3");
    step3(3'b111, 1, 1, 1, 3'b010, "n3 r4");
    step3(3'b111, 0, 1, 2, 3'b000, "n3 stall");
    pulseReset();
    step3(3'b111, 1, 1, 0, 3'b001, "n3 after rst");
    checkOutput("n3 proto_err", 32'(protoErr3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
